// File: rtl/fc_pkg.sv
// Shared types, constants and helpers for the FC TX arbiter slice.
package fc_pkg;

   localparam int unsigned NUM_TYPES = 3;
   localparam int unsigned SIZE_W    = 8;

   typedef enum logic [1:0] {
      P    = 2'b00,
      NP   = 2'b01,
      CPL  = 2'b10,
      NONE = 2'b11
   } tlp_type_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ISSUE    = 2'b01,
      WAIT_GNT = 2'b10
   } arb_state_e;

   // (ptr + step) mod 3; ptr and step never exceed 3, so the sum fits in 3 bits
   function automatic logic [1:0] rr_next(input logic [1:0] ptr, input logic [1:0] step);
      logic [2:0] s;
      s = {1'b0, ptr} + {1'b0, step};
      if (s >= 3'd6) begin
         s = s - 3'd6;
      end else if (s >= 3'd3) begin
         s = s - 3'd3;
      end
      return s[1:0];
   endfunction

   function automatic logic [NUM_TYPES-1:0] type_onehot(input logic [1:0] t);
      logic [NUM_TYPES-1:0] v;
      v = '0;
      if (t < 2'd3) begin
         v[t] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker; search begins one past the last served type.
module rr_pick3
   import fc_pkg::*;
(
   input  logic [NUM_TYPES-1:0] eligible_i,
   input  logic [1:0]           rr_ptr_i,
   output logic                 valid_o,
   output logic [1:0]           index_o
);

   logic [1:0] cand;

   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      cand    = '0;
      for (int unsigned k = 1; k <= 3; k++) begin
         cand = rr_next(rr_ptr_i, 2'(k));
         if (!valid_o && eligible_i[cand]) begin
            valid_o = 1'b1;
            index_o = cand;
         end
      end
   end

endmodule

// File: rtl/fc_tx_arbiter.sv
// Round-robin arbiter sharing the FC TX credit gate between P, NP and CPL sources,
// with per-type blocking on denial and optional timed retry.
module fc_tx_arbiter
   import fc_pkg::*;
#(
   parameter int unsigned GNT_LATENCY  = 1,
   parameter int unsigned RETRY_CYCLES = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_TYPES-1:0]        src_valid_i,
   input  logic [NUM_TYPES*SIZE_W-1:0] src_size_i,
   output logic [NUM_TYPES-1:0]        src_ready_o,
   output logic                        fc_req_o,
   output logic [1:0]                  fc_type_o,
   output logic [SIZE_W-1:0]           fc_size_o,
   input  logic                        fc_grant_i,
   input  logic                        is_initFC_i,
   input  logic                        is_updateFC_i,
   input  logic [1:0]                  type_credit_i,
   output logic [NUM_TYPES-1:0]        blocked_o,
   output logic                        busy_o
);

   localparam logic [2:0] LAT_LD   = 3'(GNT_LATENCY);
   localparam logic [7:0] RETRY_LD = 8'(RETRY_CYCLES);

   arb_state_e          state_q, state_d;
   tlp_type_e           type_q, type_d;
   logic [SIZE_W-1:0]   size_q, size_d;
   logic [1:0]          rr_ptr_q, rr_ptr_d;
   logic [2:0]          lat_cnt_q, lat_cnt_d;

   logic [NUM_TYPES-1:0] blocked;
   logic [NUM_TYPES-1:0] eligible;
   logic                 pick_valid;
   logic [1:0]           pick_idx;
   logic [1:0]           cur_type;
   logic                 gnt_sample;
   logic                 deny;
   logic                 grant_ok;
   logic                 credit_evt;

   assign eligible   = src_valid_i & ~blocked;
   assign cur_type   = type_q;
   assign gnt_sample = (state_q == WAIT_GNT) && (lat_cnt_q == 3'd1);
   assign deny       = gnt_sample && !fc_grant_i;
   assign grant_ok   = gnt_sample && fc_grant_i;
   assign credit_evt = is_initFC_i | is_updateFC_i;

   rr_pick3 u_pick (
      .eligible_i (eligible),
      .rr_ptr_i   (rr_ptr_q),
      .valid_o    (pick_valid),
      .index_o    (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         type_q    <= NONE;
         size_q    <= '0;
         rr_ptr_q  <= '0;
         lat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         size_q    <= size_d;
         rr_ptr_q  <= rr_ptr_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      size_d    = size_q;
      rr_ptr_d  = rr_ptr_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               type_d  = tlp_type_e'(pick_idx);
               size_d  = src_size_i[{pick_idx, 3'b000} +: SIZE_W];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            lat_cnt_d = LAT_LD;
            state_d   = WAIT_GNT;
         end
         WAIT_GNT: begin
            if (lat_cnt_q == 3'd1) begin
               rr_ptr_d = cur_type;
               state_d  = IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ready is gated by rst so a reset in the sampling cycle swallows the pulse
   always_comb begin
      fc_req_o    = (state_q == ISSUE);
      fc_type_o   = (state_q == ISSUE) ? type_q : NONE;
      fc_size_o   = (state_q == ISSUE) ? size_q : '0;
      src_ready_o = (grant_ok && !rst) ? type_onehot(cur_type) : '0;
      busy_o      = (state_q != IDLE);
      blocked_o   = blocked;
   end

   for (genvar t = 0; t < NUM_TYPES; t++) begin : g_type
      logic       blocked_q, blocked_d;
      logic [7:0] retry_cnt_q, retry_cnt_d;
      logic       deny_hit;
      logic       credit_hit;

      assign deny_hit   = deny && (cur_type == 2'(t));
      assign credit_hit = credit_evt && (type_credit_i == 2'(t));

      // a credit update in the same cycle as a denial leaves the type unblocked
      always_comb begin
         blocked_d   = blocked_q;
         retry_cnt_d = retry_cnt_q;
         if (deny_hit) begin
            blocked_d   = 1'b1;
            retry_cnt_d = RETRY_LD;
         end else if (blocked_q && (RETRY_CYCLES != 0)) begin
            if (retry_cnt_q <= 8'd1) begin
               retry_cnt_d = '0;
               blocked_d   = 1'b0;
            end else begin
               retry_cnt_d = retry_cnt_q - 8'd1;
            end
         end
         if (credit_hit) begin
            blocked_d   = 1'b0;
            retry_cnt_d = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            blocked_q   <= 1'b0;
            retry_cnt_q <= '0;
         end else begin
            blocked_q   <= blocked_d;
            retry_cnt_q <= retry_cnt_d;
         end
      end

      assign blocked[t] = blocked_q;
   end

endmodule

// File: tb/tb_fc_tx_arbiter.sv
// Directed bench: instance 0 uses RETRY_CYCLES=0, instance 1 RETRY_CYCLES=4; both share stimulus.
module tb_fc_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  src_valid;
   logic [23:0] src_size;
   logic        grant;
   logic        init_fc;
   logic        upd_fc;
   logic [1:0]  type_credit;

   logic [1:0][2:0] ready_w;
   logic [1:0]      req_w;
   logic [1:0][1:0] type_w;
   logic [1:0][7:0] size_w;
   logic [1:0][2:0] blk_w;
   logic [1:0]      busy_w;

   int n_chk = 0;
   int n_err = 0;

   int unsigned order [3] = '{1, 2, 0};
   logic [7:0]  exp_sz [3] = '{8'd4, 8'd8, 8'd12};

   always #5 clk = ~clk;

   fc_tx_arbiter #(.GNT_LATENCY(1), .RETRY_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .src_valid_i(src_valid), .src_size_i(src_size),
      .src_ready_o(ready_w[0]), .fc_req_o(req_w[0]), .fc_type_o(type_w[0]),
      .fc_size_o(size_w[0]), .fc_grant_i(grant), .is_initFC_i(init_fc),
      .is_updateFC_i(upd_fc), .type_credit_i(type_credit), .blocked_o(blk_w[0]),
      .busy_o(busy_w[0])
   );

   fc_tx_arbiter #(.GNT_LATENCY(1), .RETRY_CYCLES(4)) dut1 (
      .clk(clk), .rst(rst), .src_valid_i(src_valid), .src_size_i(src_size),
      .src_ready_o(ready_w[1]), .fc_req_o(req_w[1]), .fc_type_o(type_w[1]),
      .fc_size_o(size_w[1]), .fc_grant_i(grant), .is_initFC_i(init_fc),
      .is_updateFC_i(upd_fc), .type_credit_i(type_credit), .blocked_o(blk_w[1]),
      .busy_o(busy_w[1])
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int unsigned d, input logic req,
                          input logic [1:0] ty, input logic [7:0] sz, input logic [2:0] rdy,
                          input logic [2:0] blk, input logic bsy);
      string nm;
      nm = $sformatf("%s.dut%0d", tag, d);
      chk({nm, ".req"},   {7'd0, req_w[d]},  {7'd0, req});
      chk({nm, ".type"},  {6'd0, type_w[d]}, {6'd0, ty});
      chk({nm, ".size"},  size_w[d],         sz);
      chk({nm, ".ready"}, {5'd0, ready_w[d]}, {5'd0, rdy});
      chk({nm, ".blk"},   {5'd0, blk_w[d]},  {5'd0, blk});
      chk({nm, ".busy"},  {7'd0, busy_w[d]}, {7'd0, bsy});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      src_valid = '0;
      grant = 1'b0;
      init_fc = 1'b0;
      upd_fc = 1'b0;
      type_credit = 2'b00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      src_size = {8'd12, 8'd8, 8'd4};
      do_reset();

      // single P request, ready in the third cycle; valid dropped during WAIT_GNT
      src_valid = 3'b001;
      @(negedge clk); chk_out("reset", 0, 0, 2'b11, 0, 0, 0, 0); chk_out("reset", 1, 0, 2'b11, 0, 0, 0, 0); tick();
      @(negedge clk); chk_out("t1_issue", 0, 1, 2'b00, 8'd4, 0, 0, 1); tick();
      src_valid = 3'b000; grant = 1'b1;
      @(negedge clk); chk_out("t1_ready", 0, 0, 2'b11, 0, 3'b001, 0, 1); tick();
      grant = 1'b0;
      @(negedge clk); chk_out("t1_idle", 0, 0, 2'b11, 0, 0, 0, 0); tick();

      // round-robin order NP, CPL, P, NP with all grants
      do_reset();
      src_valid = 3'b111; grant = 1'b1;
      for (int i = 0; i < 12; i++) begin
         int unsigned t;
         t = order[(i / 3) % 3];
         @(negedge clk);
         if (i % 3 == 0)      chk_out($sformatf("t2_idle%0d", i), 0, 0, 2'b11, 0, 0, 0, 0);
         else if (i % 3 == 1) chk_out($sformatf("t2_issue%0d", i), 0, 1, 2'(t), exp_sz[t], 0, 0, 1);
         else                 chk_out($sformatf("t2_ready%0d", i), 0, 0, 2'b11, 0, 3'(1 << t), 0, 1);
         tick();
      end
      src_valid = 3'b000; grant = 1'b0;

      // NP denied, P and CPL keep flowing, NP resumes only after its update
      do_reset();
      src_valid = 3'b111;
      @(negedge clk); chk_out("t3_e0", 0, 0, 2'b11, 0, 0, 0, 0); tick();
      @(negedge clk); chk_out("t3_e1", 0, 1, 2'b01, 8'd8, 0, 0, 1); tick();
      grant = 1'b0;
      @(negedge clk); chk_out("t3_e2", 0, 0, 2'b11, 0, 0, 0, 1); tick();
      grant = 1'b1;
      @(negedge clk); chk_out("t3_e3", 0, 0, 2'b11, 0, 0, 3'b010, 0); tick();
      @(negedge clk); chk_out("t3_e4", 0, 1, 2'b10, 8'd12, 0, 3'b010, 1); tick();
      @(negedge clk); chk_out("t3_e5", 0, 0, 2'b11, 0, 3'b100, 3'b010, 1); tick();
      @(negedge clk); chk_out("t3_e6", 0, 0, 2'b11, 0, 0, 3'b010, 0); tick();
      @(negedge clk); chk_out("t3_e7", 0, 1, 2'b00, 8'd4, 0, 3'b010, 1); tick();
      @(negedge clk); chk_out("t3_e8", 0, 0, 2'b11, 0, 3'b001, 3'b010, 1); tick();
      src_valid = 3'b010;
      @(negedge clk); chk_out("t3_e9", 0, 0, 2'b11, 0, 0, 3'b010, 0); tick();
      upd_fc = 1'b1; type_credit = 2'b11;
      @(negedge clk); chk_out("t3_e10", 0, 0, 2'b11, 0, 0, 3'b010, 0); tick();
      type_credit = 2'b01;
      @(negedge clk); chk_out("t3_e11", 0, 0, 2'b11, 0, 0, 3'b010, 0); tick();
      upd_fc = 1'b0;
      @(negedge clk); chk_out("t3_e12", 0, 0, 2'b11, 0, 0, 0, 0); tick();
      @(negedge clk); chk_out("t3_e13", 0, 1, 2'b01, 8'd8, 0, 0, 1); tick();
      @(negedge clk); chk_out("t3_e14", 0, 0, 2'b11, 0, 3'b010, 0, 1); tick();
      src_valid = 3'b000; grant = 1'b0;
      @(negedge clk); chk_out("t3_e15", 0, 0, 2'b11, 0, 0, 0, 0); tick();

      // denial and update for P in the same cycle: P stays unblocked
      do_reset();
      src_valid = 3'b001;
      @(negedge clk); chk_out("t4_f0", 0, 0, 2'b11, 0, 0, 0, 0); tick();
      @(negedge clk); chk_out("t4_f1", 0, 1, 2'b00, 8'd4, 0, 0, 1); tick();
      grant = 1'b0; upd_fc = 1'b1; type_credit = 2'b00;
      @(negedge clk); chk_out("t4_f2", 0, 0, 2'b11, 0, 0, 0, 1); tick();
      upd_fc = 1'b0; grant = 1'b1;
      @(negedge clk); chk_out("t4_f3", 0, 0, 2'b11, 0, 0, 0, 0); tick();
      @(negedge clk); chk_out("t4_f4", 0, 1, 2'b00, 8'd4, 0, 0, 1); tick();
      @(negedge clk); chk_out("t4_f5", 0, 0, 2'b11, 0, 3'b001, 0, 1); tick();
      src_valid = 3'b000; grant = 1'b0;

      // CPL denied: dut1 retries after 4 blocked cycles, dut0 stays blocked
      do_reset();
      src_valid = 3'b100;
      @(negedge clk); chk_out("t5_g0", 1, 0, 2'b11, 0, 0, 0, 0); tick();
      @(negedge clk); chk_out("t5_g1", 1, 1, 2'b10, 8'd12, 0, 0, 1); chk_out("t5_g1", 0, 1, 2'b10, 8'd12, 0, 0, 1); tick();
      @(negedge clk); chk_out("t5_g2", 1, 0, 2'b11, 0, 0, 0, 1); tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_out($sformatf("t5_blk%0d", i), 1, 0, 2'b11, 0, 0, 3'b100, 0);
         chk_out($sformatf("t5_blk%0d", i), 0, 0, 2'b11, 0, 0, 3'b100, 0);
         tick();
      end
      @(negedge clk); chk_out("t5_g7", 1, 0, 2'b11, 0, 0, 0, 0); chk_out("t5_g7", 0, 0, 2'b11, 0, 0, 3'b100, 0); tick();
      @(negedge clk); chk_out("t5_g8", 1, 1, 2'b10, 8'd12, 0, 0, 1); chk_out("t5_g8", 0, 0, 2'b11, 0, 0, 3'b100, 0); tick();
      grant = 1'b1;
      @(negedge clk); chk_out("t5_g9", 1, 0, 2'b11, 0, 3'b100, 0, 1); chk_out("t5_g9", 0, 0, 2'b11, 0, 0, 3'b100, 0); tick();
      grant = 1'b0;

      // reset during the grant-sampling cycle swallows the ready pulse
      src_valid = 3'b001;
      @(negedge clk); chk_out("t6_h0", 0, 0, 2'b11, 0, 0, 3'b100, 0); tick();
      @(negedge clk); chk_out("t6_h1", 0, 1, 2'b00, 8'd4, 0, 3'b100, 1); chk_out("t6_h1", 1, 1, 2'b00, 8'd4, 0, 0, 1); tick();
      grant = 1'b1; rst = 1'b1;
      @(negedge clk); chk_out("t6_h2", 0, 0, 2'b11, 0, 0, 3'b100, 1); chk_out("t6_h2", 1, 0, 2'b11, 0, 0, 0, 1); tick();
      rst = 1'b0; src_valid = 3'b000; grant = 1'b0;
      @(negedge clk); chk_out("t6_h3", 0, 0, 2'b11, 0, 0, 0, 0); chk_out("t6_h3", 1, 0, 2'b11, 0, 0, 0, 0); tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fc_tx_arbiter.md
Name: fc_tx_arbiter

Overview:
- Shares the FC TX credit gate (FC_TX_Controller_Top) between three TLP sources: Posted (MWr, type 2'b00), Non-Posted (MRd, 2'b01) and Completion (Cpl, 2'b10).
- Selects one pending request round-robin and issues it to the gate as a single-cycle pulse. It then samples the grant and returns accept to the winning source.
- Marks a denied type as blocked until an UpdateFC/InitFC for that type arrives, or until the retry timer expires. This stops one credit-starved type from stalling the others.

Parameters:
- GNT_LATENCY, 1: cycles from fc_req_o pulse to the cycle in which fc_grant_i is valid (1..7).
- RETRY_CYCLES, 0: cycles after denial before a blocked type is retried without a credit update; 0 = retry only on update (0..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- src_valid_i  in  3  per-type request pending; bit index = type code.
- src_size_i  in  24  per-type payload size in DW, 8 bits per type, [8t+7:8t]; 0 legal.
- src_ready_o  out  3  one-cycle accept pulse to the granted type.
- fc_req_o  out  1  request pulse to the credit gate.
- fc_type_o  out  2  type of the issued request; 2'b11 when idle.
- fc_size_o  out  8  size of the issued request; 0 when idle.
- fc_grant_i  in  1  gate result, valid GNT_LATENCY cycles after fc_req_o.
- is_initFC_i  in  1  credit-init snoop.
- is_updateFC_i  in  1  credit-update snoop.
- type_credit_i  in  2  type of the credit being init/updated.
- blocked_o  out  3  per-type blocked status.
- busy_o  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset values: FSM IDLE; all outputs 0 except fc_type_o = 2'b11. blocked cleared, rr_ptr = 0, retry counters 0.
- Reset mid-transaction aborts it silently: no src_ready_o pulse, and the pending grant is ignored.
- FSM states: IDLE, ISSUE, WAIT_GNT.
- IDLE:
  - eligible = src_valid_i & ~blocked.
  - Search order starts at rr_ptr+1 mod 3 (rr_ptr = last served type).
  - If any type is eligible: latch its type and size, go to ISSUE.
- ISSUE:
  - fc_req_o = 1 for exactly one cycle, with fc_type_o/fc_size_o = latched values.
  - Load the latency counter with GNT_LATENCY, go to WAIT_GNT.
  - fc_req_o must never be high for two consecutive cycles; the gate charges credit per asserted cycle.
- WAIT_GNT:
  - Decrement the counter each cycle; sample fc_grant_i when the counter reaches 1.
  - Grant = 1: src_ready_o[type] = 1 for that cycle, rr_ptr = type, go to IDLE.
  - Grant = 0: set blocked[type], load retry_cnt[type] = RETRY_CYCLES, advance rr_ptr = type, go to IDLE.
  - fc_grant_i is ignored in every other cycle.
- Latency: IDLE select → ISSUE → WAIT_GNT is at least 2 + GNT_LATENCY cycles from valid to ready. Back-to-back throughput is one request per 2 + GNT_LATENCY cycles.
- Blocked clear: blocked[t] clears when is_updateFC_i or is_initFC_i is high with type_credit_i == t. A type_credit_i of 2'b11 clears nothing.
- Simultaneous denial-set and update-clear on the same type in the same cycle: clear wins.
- Retry timer:
  - When RETRY_CYCLES > 0, retry_cnt[t] decrements while blocked[t] is set.
  - blocked[t] clears when the count reaches 0 at the same cycle boundary.
- Sources must hold src_valid_i and src_size_i stable until src_ready_o. The latched size is used even if src_size_i changes.
- A deasserted src_valid_i while the FSM is in WAIT_GNT does not abort the transaction; the ready pulse is still issued.
- All types blocked with valid pending: remain in IDLE; busy_o = 0.

Decomposition:
- Shared package fc_pkg:
  - tlp_type_e (P = 2'b00, NP = 2'b01, CPL = 2'b10, NONE = 2'b11).
  - arb_state_e.
  - NUM_TYPES = 3.
  - SIZE_W = 8.
- Sub-module rr_pick3: combinational 3-way round-robin picker; inputs eligible and rr_ptr, outputs valid and index.
- Retry counters stay inline (generate loop).

Test Plan:
- Single P request, size 4, gate grants (GNT_LATENCY = 1) → exactly one fc_req_o pulse with type 00, size 4; src_ready_o = 3'b001 three cycles after src_valid_i rises; blocked_o stays 0.
- P, NP and CPL all held valid with grants always 1 → issue order NP, CPL, P, NP… (rr_ptr starts at 0); each fc_req_o pulse is one cycle wide, separated by two idle cycles.
- NP denied (fc_grant_i = 0), P and CPL valid → blocked_o = 3'b010; P and CPL continue to be served; no NP issue until is_updateFC_i = 1 with type_credit_i = 01, after which NP is reissued and granted.
- Denial and an update for the same type (is_updateFC_i = 1, type_credit_i = 00) in the same cycle → blocked_o[0] remains 0; P is reissued on the next IDLE selection.
- RETRY_CYCLES = 4, CPL denied, no updates → blocked_o[2] is high for 4 cycles, then CPL is reissued automatically.
- rst asserted during WAIT_GNT with fc_grant_i = 1 in the same cycle → no src_ready_o pulse; the next cycle shows fc_type_o = 11, blocked_o = 0, busy_o = 0.
